// File: rtl/iir_sos_seq_pkg.sv
// ---------------------------------------------------------------------------
// iir_sos_seq_pkg
// Shared definitions for the second-order-section cascade sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - CA_*        : coefficient select codes carried on cfg_addr / sec_c_addr
// ---------------------------------------------------------------------------
package iir_sos_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC0 = 2'd1,
    ST_MAC1 = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_t;

  localparam logic [1:0] CA_A1 = 2'd0;
  localparam logic [1:0] CA_A2 = 2'd1;
  localparam logic [1:0] CA_B  = 2'd2;
  localparam logic [1:0] CA_K  = 2'd3;

endpackage

// File: rtl/iir_sos_seq.sv
// ---------------------------------------------------------------------------
// iir_sos_seq
// Time-multiplexes N_SEC cascaded second-order sections. Each accepted sample
// walks through the sections one at a time: MAC0 (a-path, mult_sel=0), MAC1
// (delay path, mult_sel=1), GAP (ce low so the section latches its result).
// Coefficient writes are accepted only while idle and forwarded one cycle
// later as a one-hot strobe with the captured address/data.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : sample handshake at the cascade input
//   out_valid         : one-cycle pulse when the last section has updated
//   cfg_we/cfg_sec/cfg_addr/cfg_data/cfg_ready : coefficient write request
//   sec_ce            : per-section compute enable (at most one bit high)
//   sec_mult_sel      : shared a-coefficient / delay select
//   sec_c_we/sec_c_addr/sec_c_in : coefficient write strobe, address, data
//   busy              : sequence in progress
//   err_cfg/err_overrun : sticky error flags, cleared by err_clr
// ---------------------------------------------------------------------------
module iir_sos_seq
  import iir_sos_seq_pkg::*;
#(
  parameter int N_SEC   = 4,
  parameter int COEFF_W = 16,
  parameter int SEC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               cfg_we,
  input  logic [SEC_W-1:0]   cfg_sec,
  input  logic [1:0]         cfg_addr,
  input  logic [COEFF_W-1:0] cfg_data,
  output logic               cfg_ready,
  output logic [N_SEC-1:0]   sec_ce,
  output logic               sec_mult_sel,
  output logic [N_SEC-1:0]   sec_c_we,
  output logic [1:0]         sec_c_addr,
  output logic [COEFF_W-1:0] sec_c_in,
  output logic               busy,
  output logic               err_cfg,
  output logic               err_overrun,
  input  logic               err_clr
);

  seq_state_t         state_r, state_s;
  logic [SEC_W-1:0]   sec_cnt_r, sec_cnt_s;
  logic               last_s;
  logic               accept_s;
  logic               wr_s;
  logic               run_s;
  logic [N_SEC-1:0]   ce_s;
  logic [N_SEC-1:0]   cwe_s;
  logic               msel_s;
  logic               ovalid_s;
  logic               cfg_bad_s;
  logic               overrun_s;

  // Handshakes are forced low while reset is held; a write beats a sample.
  assign busy      = (state_r != ST_IDLE);
  assign cfg_ready = !rst && (state_r == ST_IDLE);
  assign in_ready  = !rst && (state_r == ST_IDLE) && !cfg_we;
  assign accept_s  = in_valid && in_ready;
  assign wr_s      = cfg_we && cfg_ready;
  assign last_s    = (int'(sec_cnt_r) == (N_SEC - 1));
  assign cfg_bad_s = wr_s && (int'(cfg_sec) >= N_SEC);
  assign overrun_s = in_valid && busy;

  // Next-state and section-counter logic.
  always_comb begin
    state_s   = state_r;
    sec_cnt_s = sec_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_MAC0;
          sec_cnt_s = {SEC_W{1'b0}};
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_MAC0: state_s = ST_MAC1;
      ST_MAC1: state_s = ST_GAP;
      ST_GAP: begin
        if (last_s) begin
          state_s   = ST_IDLE;
          sec_cnt_s = {SEC_W{1'b0}};
        end else begin
          state_s   = ST_MAC0;
          sec_cnt_s = sec_cnt_r + SEC_W'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        sec_cnt_s = {SEC_W{1'b0}};
      end
    endcase
  end

  // Output values derived from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    ce_s     = {N_SEC{1'b0}};
    cwe_s    = {N_SEC{1'b0}};
    run_s    = (state_s == ST_MAC0) || (state_s == ST_MAC1);
    msel_s   = (state_s == ST_MAC1);
    ovalid_s = (state_r == ST_GAP) && last_s;
    for (int i = 0; i < N_SEC; i++) begin
      ce_s[i]  = run_s && (int'(sec_cnt_s) == i);
      // Out-of-range section indices match no bit, so no strobe is issued.
      cwe_s[i] = wr_s && (int'(cfg_sec) == i);
    end
  end

  // State, registered outputs, coefficient stage and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sec_cnt_r    <= {SEC_W{1'b0}};
      sec_ce       <= {N_SEC{1'b0}};
      sec_mult_sel <= 1'b0;
      out_valid    <= 1'b0;
      sec_c_we     <= {N_SEC{1'b0}};
      sec_c_addr   <= CA_A1;
      sec_c_in     <= {COEFF_W{1'b0}};
      err_cfg      <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state_r      <= state_s;
      sec_cnt_r    <= sec_cnt_s;
      sec_ce       <= ce_s;
      sec_mult_sel <= msel_s;
      out_valid    <= ovalid_s;
      sec_c_we     <= cwe_s;
      if (wr_s) begin
        sec_c_addr <= cfg_addr;
        sec_c_in   <= cfg_data;
      end else begin
        sec_c_addr <= sec_c_addr;
        sec_c_in   <= sec_c_in;
      end
      // A set event in the same cycle as err_clr keeps the flag set.
      err_cfg     <= cfg_bad_s ? 1'b1 : (err_clr ? 1'b0 : err_cfg);
      err_overrun <= overrun_s ? 1'b1 : (err_clr ? 1'b0 : err_overrun);
    end
  end

endmodule

// File: doc/iir_sos_seq.md
IIR_SOS_SEQ -- requirements
Module: iir_sos_seq

Interface
REQ-001 Parameter N_SEC, default 4, number of cascaded second-order sections sequenced (1..16).
REQ-002 Parameter COEFF_W, default 16, coefficient word width (matches section COEFF_WH+COEFF_FR).
REQ-003 Parameter SEC_W, default 4, width of section index, SHALL satisfy 2**SEC_W >= N_SEC.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  new input sample present at cascade input.
REQ-007 in_ready  out  1  sequencer can accept a sample.
REQ-008 out_valid  out  1  one-cycle pulse: last section output register updated.
REQ-009 cfg_we  in  1  coefficient write request.
REQ-010 cfg_sec  in  SEC_W  target section index.
REQ-011 cfg_addr  in  2  coefficient select (0 a1, 1 a2, 2 b, 3 K).
REQ-012 cfg_data  in  COEFF_W  coefficient value.
REQ-013 cfg_ready  out  1  write accepted this cycle when high with cfg_we.
REQ-014 sec_ce  out  N_SEC  per-section compute enable, at most one bit high.
REQ-015 sec_mult_sel  out  1  shared a-coefficient/delay select.
REQ-016 sec_c_we  out  N_SEC  per-section coefficient write strobe.
REQ-017 sec_c_addr  out  2 / sec_c_in  out  COEFF_W  shared coefficient address/data.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 err_cfg / err_overrun  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-020 FSM states IDLE, MAC0, MAC1, GAP; section counter sec_cnt (SEC_W bits).
REQ-021 IDLE: in_ready = !cfg_we; cfg_ready = 1; in MAC0/MAC1/GAP both low.
REQ-022 IDLE & in_valid & in_ready -> MAC0, sec_cnt=0.
REQ-023 MAC0: sec_ce[sec_cnt]=1, sec_mult_sel=0; -> MAC1.
REQ-024 MAC1: sec_ce[sec_cnt]=1, sec_mult_sel=1; -> GAP.
REQ-025 GAP: sec_ce all 0, sec_mult_sel=0 (section self-detects ce falling edge and updates state/output); if sec_cnt==N_SEC-1 -> IDLE, else sec_cnt+1 -> MAC0.
REQ-026 out_valid SHALL pulse for one cycle in the cycle after the final GAP (first IDLE cycle); latency accept-to-out_valid = 3*N_SEC+1 cycles.
REQ-027 A sample may be accepted in the same cycle out_valid is high; sustained throughput one sample per 3*N_SEC+1 cycles.
REQ-028 in_valid high while busy SHALL set err_overrun; the sample is dropped, sequence unaffected.
REQ-029 Accepted write (cfg_we & cfg_ready) SHALL be registered; next cycle sec_c_we[cfg_sec] pulses once with sec_c_addr/sec_c_in = captured cfg_addr/cfg_data.
REQ-030 cfg_we and in_valid together in IDLE: write wins, sample not accepted this cycle.
REQ-031 cfg_sec >= N_SEC on accepted write: no strobe, err_cfg set.
REQ-032 err_clr SHALL clear flags; a simultaneous set event takes priority over clear.
REQ-033 sec_ce, sec_mult_sel, sec_c_we, out_valid SHALL be register outputs (glitch-free).

Reset
REQ-034 rst high: state IDLE, sec_cnt 0, sec_ce 0, sec_mult_sel 0, sec_c_we 0, sec_c_addr 0, sec_c_in 0, out_valid 0, busy 0, error flags 0, in_ready/cfg_ready 0 while rst held.
REQ-035 rst mid-sequence SHALL abort immediately; no out_valid for the aborted sample; pending write strobe discarded.

Structure
REQ-036 Shared package holds FSM state encoding and coefficient address constants (A1=0, A2=1, B=2, K=3).
REQ-037 Single module, no sub-modules; configuration register stage kept inline.

Verification
REQ-038 N_SEC=4, single in_valid pulse at cycle 0 -> sec_ce bits 0,1,2,3 high at cycles 1-2, 4-5, 7-8, 10-11; mult_sel 1 at 2,5,8,11; out_valid at cycle 13.
REQ-039 in_valid held high continuously -> accepts at cycles 0,13,26; err_overrun set at cycle 1.
REQ-040 cfg_we, cfg_sec=2, cfg_addr=3, cfg_data=16'h4000 in IDLE -> next cycle sec_c_we=4'b0100, sec_c_addr=3, sec_c_in=16'h4000.
REQ-041 cfg_we and in_valid same IDLE cycle -> write forwarded, in_ready 0, sample accepted next cycle (out_valid 14 cycles after original).
REQ-042 cfg_sec=5 with N_SEC=4 -> sec_c_we stays 0, err_cfg=1; err_clr -> 0.
REQ-043 rst asserted at cycle 5 of a sequence -> all outputs 0 same cycle, no out_valid; next sample after release completes normally.
